viterbi_acs_sched: RTL and testbench

Sequencer for the folded branch-metric/add-compare-select datapath of the K=7, 64-state hard-decision Viterbi decoder. It accepts one 2-bit received pair per symbol and time-multiplexes the 32 butterflies over a smaller BMC/ACS array, one butterfly group per cycle. It also manages the path-metric ping-pong bank, metric normalisation, survivor-memory write addressing and traceback launches. It sits between the input symbol stream and the BMC/ACS array, survivor RAM and traceback unit.

---
 rtl/viterbi_pkg.sv | 22 ++
 rtl/viterbi_acs_sched_if.sv | 24 ++
 rtl/viterbi_seg_tracker.sv | 61 ++++++
 rtl/viterbi_acs_sched.sv | 116 +++++++++++
 tb/tb_viterbi_acs_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared parameters, derived widths and FSM state type
// for the folded K=7 Viterbi BMC/ACS scheduler.
package viterbi_pkg;

    localparam int NUM_BFLY     = 32;
    localparam int BFLY_PER_CYC = 8;
    localparam int NUM_GRP      = NUM_BFLY / BFLY_PER_CYC;
    localparam int TB_LEN       = 32;
    localparam int SM_DEPTH     = 2 * TB_LEN;

    localparam int GRP_W = $clog2(NUM_GRP);
    localparam int COL_W = $clog2(SM_DEPTH);
    localparam int LEN_W = $clog2(TB_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACS,
        COMMIT,
        WAIT_TB
    } sched_state_t;

endpackage

// File: rtl/viterbi_acs_sched_if.sv
// Received-symbol stream handshake into the ACS scheduler.
// master drives symbols, slave returns ready.
interface viterbi_acs_sched_if;

    logic       rx_valid;
    logic [1:0] rx_pair;
    logic       rx_last;
    logic       rx_ready;

    modport master (
        output rx_valid,
        output rx_pair,
        output rx_last,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_pair,
        input  rx_last,
        output rx_ready
    );

endinterface

// File: rtl/viterbi_seg_tracker.sv
// Survivor column / segment bookkeeping: decides segment close,
// latches traceback launch parameters and flags frame end.
module viterbi_seg_tracker
    import viterbi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic             rx_last,
    input  logic             commit,
    input  logic             launch,
    output logic             close,
    output logic             frame_rst,
    output logic [COL_W-1:0] col,
    output logic             tb_start,
    output logic [COL_W-1:0] tb_col,
    output logic [LEN_W-1:0] tb_len,
    output logic             frame_done
);

    logic             last_q;
    logic             fin_q;
    logic [LEN_W-1:0] seg_cnt;
    logic [LEN_W-1:0] seg_nxt;

    assign seg_nxt   = seg_cnt + LEN_W'(1);
    assign close     = commit & ((seg_nxt == LEN_W'(TB_LEN)) | last_q);
    assign frame_rst = tb_start & fin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 1'b0;
            fin_q      <= 1'b0;
            seg_cnt    <= '0;
            col        <= '0;
            tb_start   <= 1'b0;
            tb_col     <= '0;
            tb_len     <= '0;
            frame_done <= 1'b0;
        end else begin
            tb_start   <= launch;
            frame_done <= frame_rst;
            if (accept) last_q <= rx_last;
            if (launch) fin_q <= last_q;
            if (commit) begin
                col     <= col + COL_W'(1);
                seg_cnt <= close ? '0 : seg_nxt;
                // held here so a stalled launch still sees this segment
                if (close) begin
                    tb_col <= col;
                    tb_len <= seg_nxt;
                end
            end
            if (frame_rst) begin
                col     <= '0;
                seg_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/viterbi_acs_sched.sv
// Symbol-rate sequencer folding 32 butterflies over the ACS array,
// with path-metric ping-pong, normalisation and traceback launch.
module viterbi_acs_sched
    import viterbi_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    viterbi_acs_sched_if.slave     rx,
    output logic [1:0]             bmc_pair,
    output logic                   acs_en,
    output logic [GRP_W-1:0]       acs_grp,
    output logic                   pm_bank,
    input  logic                   norm_flag,
    output logic                   norm_en,
    output logic                   surv_we,
    output logic [COL_W+GRP_W-1:0] surv_waddr,
    input  logic                   tb_busy,
    output logic                   tb_start,
    output logic [COL_W-1:0]       tb_col,
    output logic [LEN_W-1:0]       tb_len,
    output logic                   frame_done
);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic             accept;
    logic             commit;
    logic             launch;
    logic             close;
    logic             frame_rst;
    logic             norm_acc;
    logic [COL_W-1:0] col;

    assign accept     = (state == IDLE) & rx.rx_valid;
    assign surv_we    = acs_en;
    assign surv_waddr = {col, acs_grp};

    always_comb begin
        state_nxt   = state;
        rx.rx_ready = 1'b0;
        acs_en      = 1'b0;
        commit      = 1'b0;
        launch      = 1'b0;
        unique case (state)
            IDLE: begin
                rx.rx_ready = 1'b1;
                if (rx.rx_valid) state_nxt = ACS;
            end
            ACS: begin
                acs_en = 1'b1;
                if (acs_grp == GRP_W'(NUM_GRP - 1)) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
                if (close && tb_busy) state_nxt = WAIT_TB;
                launch = close & ~tb_busy;
            end
            WAIT_TB: begin
                if (!tb_busy) begin
                    launch    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bmc_pair <= '0;
            acs_grp  <= '0;
            pm_bank  <= 1'b0;
            norm_en  <= 1'b0;
            norm_acc <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bmc_pair <= rx.rx_pair;
                acs_grp  <= '0;
            end else if (acs_en) begin
                acs_grp <= acs_grp + GRP_W'(1);
            end
            if (acs_en && norm_flag) norm_acc <= 1'b1;
            if (commit) begin
                pm_bank  <= ~pm_bank;
                norm_en  <= norm_acc;
                norm_acc <= 1'b0;
            end
            // a finished frame restarts from bank 0, un-normalised
            if (frame_rst) begin
                pm_bank  <= 1'b0;
                norm_en  <= 1'b0;
                norm_acc <= 1'b0;
            end
        end
    end

    viterbi_seg_tracker u_seg (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept),
        .rx_last    (rx.rx_last),
        .commit     (commit),
        .launch     (launch),
        .close      (close),
        .frame_rst  (frame_rst),
        .col        (col),
        .tb_start   (tb_start),
        .tb_col     (tb_col),
        .tb_len     (tb_len),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Self-checking bench for viterbi_acs_sched: vector table, directed
// corner sequences and randomized frames against a symbol-level model.
module tb_viterbi_acs_sched;
    import viterbi_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [1:0]             bmc_pair;
    logic                   acs_en;
    logic [GRP_W-1:0]       acs_grp;
    logic                   pm_bank;
    logic                   norm_flag = 1'b0;
    logic                   norm_en;
    logic                   surv_we;
    logic [COL_W+GRP_W-1:0] surv_waddr;
    logic                   tb_busy = 1'b0;
    logic                   tb_start;
    logic [COL_W-1:0]       tb_col;
    logic [LEN_W-1:0]       tb_len;
    logic                   frame_done;

    viterbi_acs_sched_if rx();

    viterbi_acs_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .bmc_pair   (bmc_pair),
        .acs_en     (acs_en),
        .acs_grp    (acs_grp),
        .pm_bank    (pm_bank),
        .norm_flag  (norm_flag),
        .norm_en    (norm_en),
        .surv_we    (surv_we),
        .surv_waddr (surv_waddr),
        .tb_busy    (tb_busy),
        .tb_start   (tb_start),
        .tb_col     (tb_col),
        .tb_len     (tb_len),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_mode = 0;
    int flag_pct = 0;
    int busy_left = 0;
    int acc_cyc[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // symbol-level reference: column = symbol index mod depth, bank =
    // symbol parity, segments of TB_LEN or cut by rx_last
    typedef struct {
        int col;
        int len;
        bit last;
    } launch_t;

    launch_t exp_q[$];
    launch_t e;
    int  ts_col[$];
    int  ts_len[$];
    int  fd_cnt = 0;
    int  fcnt, seg, cur_sym, grp_e, cur_pair, exp_norm;
    bit  cur_or, fd_next, prev_busy;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            fcnt = 0; seg = 0; cur_sym = 0; grp_e = 0; cur_pair = 0;
            exp_norm = 0; cur_or = 0; fd_next = 0; prev_busy = 0;
        end else begin
            if (frame_done || fd_next) chk("frame_done", frame_done, fd_next);
            fd_next = 0;
            if (frame_done) fd_cnt++;
            if (tb_start) begin
                ts_col.push_back(tb_col);
                ts_len.push_back(tb_len);
                chk("launch_while_busy", prev_busy, 0);
                if (exp_q.size() == 0) begin
                    chk("tb_start_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tb_col", tb_col, e.col);
                    chk("tb_len", tb_len, e.len);
                    fd_next = e.last;
                end
            end
            if (acs_en) begin
                chk("acs_grp", acs_grp, grp_e);
                chk("bmc_pair", bmc_pair, cur_pair);
                chk("pm_bank", pm_bank, cur_sym % 2);
                chk("norm_en", norm_en, exp_norm);
                chk("surv_waddr", surv_waddr,
                    (cur_sym % SM_DEPTH) * NUM_GRP + grp_e);
                chk("surv_we", surv_we, 1);
                cur_or |= norm_flag;
                grp_e = (grp_e + 1) % NUM_GRP;
            end
            if (rx.rx_valid && rx.rx_ready) begin
                exp_norm = (fcnt == 0) ? 0 : int'(cur_or);
                cur_or = 0;
                cur_sym = fcnt;
                cur_pair = rx.rx_pair;
                grp_e = 0;
                fcnt++;
                seg++;
                if (seg == TB_LEN || rx.rx_last) begin
                    exp_q.push_back('{cur_sym % SM_DEPTH, seg, rx.rx_last});
                    seg = 0;
                    if (rx.rx_last) fcnt = 0;
                end
            end
            prev_busy = tb_busy;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // advance to just after the next rising edge and drive side inputs
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy_mode == 1 && tb_start && $urandom_range(0, 1) == 1)
            busy_left = $urandom_range(1, 45);
        tb_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        norm_flag = (flag_pct > 0) && ($urandom_range(0, 99) < flag_pct);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx.rx_valid = 1'b0;
        rx.rx_last = 1'b0;
        rx.rx_pair = 2'b00;
        tb_busy = 1'b0;
        norm_flag = 1'b0;
        busy_left = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = rx.rx_ready;
            if (ok) acc_cyc.push_back(cyc);
            tick();
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic feed(int n, bit last_end, int gap_max);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            rx.rx_valid = 1'b0;
            repeat (g) tick();
            rx.rx_valid = 1'b1;
            rx.rx_pair = 2'($urandom);
            rx.rx_last = last_end && (i == n - 1);
            wait_accept();
        end
        rx.rx_valid = 1'b0;
        rx.rx_last = 1'b0;
    endtask

    task automatic drain(int n);
        repeat (n) tick();
        chk("launch_pending", exp_q.size(), 0);
    endtask

    task automatic norm_sym(output int ones);
        ones = 0;
        rx.rx_valid = 1'b1;
        rx.rx_pair = 2'($urandom);
        wait_accept();
        rx.rx_valid = 1'b0;
        for (int k = 0; k < NUM_GRP; k++) begin
            @(negedge clk);
            if (acs_en && norm_en) ones++;
            tick();
        end
    endtask

    typedef struct {
        bit v; int pair; bit last;
        bit rdy; bit acs; int grp; bit pm; bit ts; bit fd; int bmc; int len;
    } vec_t;

    vec_t vec[10];

    initial begin
        int base, bad, n1, n2, fd0;

        vec[0] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vec[1] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        vec[2] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        vec[3] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
        vec[4] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0};
        vec[5] = '{0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0};
        vec[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vec[7] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1};
        vec[8] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1};
        vec[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};

        do_reset();
        chk("reset_norm_en", norm_en, 0);
        chk("reset_frame_done", frame_done, 0);
        for (int k = 0; k < 10; k++) begin
            rx.rx_valid = vec[k].v;
            rx.rx_pair = 2'(vec[k].pair);
            rx.rx_last = vec[k].last;
            @(negedge clk);
            chk($sformatf("v%0d_rx_ready", k), rx.rx_ready, vec[k].rdy);
            chk($sformatf("v%0d_acs_en", k), acs_en, vec[k].acs);
            chk($sformatf("v%0d_surv_we", k), surv_we, vec[k].acs);
            chk($sformatf("v%0d_acs_grp", k), acs_grp, vec[k].grp);
            chk($sformatf("v%0d_pm_bank", k), pm_bank, vec[k].pm);
            chk($sformatf("v%0d_tb_start", k), tb_start, vec[k].ts);
            chk($sformatf("v%0d_frame_done", k), frame_done, vec[k].fd);
            chk($sformatf("v%0d_bmc_pair", k), bmc_pair, vec[k].bmc);
            chk($sformatf("v%0d_tb_col", k), tb_col, 0);
            chk($sformatf("v%0d_tb_len", k), tb_len, vec[k].len);
            @(posedge clk);
            #1;
        end

        // 64 back-to-back symbols, no stall
        do_reset();
        acc_cyc.delete();
        base = ts_col.size();
        feed(64, 0, 0);
        drain(10);
        bad = 0;
        for (int i = 1; i < acc_cyc.size(); i++)
            if (acc_cyc[i] - acc_cyc[i-1] != NUM_GRP + 2) bad++;
        chk("accept_count", acc_cyc.size(), 64);
        chk("accept_spacing_bad", bad, 0);
        chk("b2b_launches", ts_col.size() - base, 2);
        if (ts_col.size() - base == 2) begin
            chk("b2b_col0", ts_col[base], 31);
            chk("b2b_col1", ts_col[base+1], 63);
            chk("b2b_len0", ts_len[base], 32);
            chk("b2b_len1", ts_len[base+1], 32);
        end

        // traceback busy for 10 cycles from the symbol-32 commit
        do_reset();
        feed(31, 0, 0);
        rx.rx_valid = 1'b1;
        rx.rx_pair = 2'b10;
        rx.rx_last = 1'b0;
        wait_accept();
        rx.rx_valid = 1'b1;
        repeat (3) tick();
        busy_left = 10;
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_rx_ready", k), rx.rx_ready, 0);
            chk($sformatf("stall%0d_tb_start", k), tb_start, 0);
            tick();
        end
        @(negedge clk);
        chk("stall_release_tb_start", tb_start, 0);
        tick();
        @(negedge clk);
        chk("stall_tb_start", tb_start, 1);
        chk("stall_tb_col", tb_col, 31);
        chk("stall_tb_len", tb_len, 32);
        chk("stall_rx_ready", rx.rx_ready, 1);
        tick();
        rx.rx_valid = 1'b0;
        drain(10);

        // normalisation request seen one symbol late, for one symbol
        do_reset();
        rx.rx_valid = 1'b1;
        rx.rx_pair = 2'b11;
        rx.rx_last = 1'b0;
        wait_accept();
        rx.rx_valid = 1'b0;
        tick();
        tick();
        norm_flag = 1'b1;
        tick();
        norm_sym(n1);
        chk("norm_next_symbol", n1, NUM_GRP);
        norm_sym(n2);
        chk("norm_symbol_after", n2, 0);

        // 70-symbol frame: wrapped final short segment
        do_reset();
        flag_pct = 30;
        base = ts_col.size();
        fd0 = fd_cnt;
        feed(70, 1, 2);
        flag_pct = 0;
        drain(30);
        chk("f70_launches", ts_col.size() - base, 3);
        if (ts_col.size() - base == 3) begin
            chk("f70_col2", ts_col[base+2], 5);
            chk("f70_len2", ts_len[base+2], 6);
        end
        chk("f70_frame_done", fd_cnt - fd0, 1);

        // asynchronous reset in the middle of ACS group 2
        do_reset();
        feed(5, 0, 0);
        rx.rx_valid = 1'b1;
        rx.rx_pair = 2'b01;
        wait_accept();
        rx.rx_valid = 1'b0;
        tick();
        tick();
        chk("pre_reset_grp", acs_grp, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_acs_en", acs_en, 0);
        chk("rst_rx_ready", rx.rx_ready, 1);
        chk("rst_acs_grp", acs_grp, 0);
        chk("rst_surv_waddr", surv_waddr, 0);
        chk("rst_pm_bank", pm_bank, 0);
        chk("rst_tb_start", tb_start, 0);
        base = ts_col.size();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drain(20);
        chk("rst_no_launch", ts_col.size() - base, 0);
        feed(3, 1, 0);
        drain(20);
        chk("rst_next_launches", ts_col.size() - base, 1);
        if (ts_col.size() - base == 1) begin
            chk("rst_next_col", ts_col[base], 2);
            chk("rst_next_len", ts_len[base], 3);
        end

        // randomized frames with random traceback occupancy
        do_reset();
        fd0 = fd_cnt;
        busy_mode = 1;
        flag_pct = 25;
        feed(150, 1, 3);
        feed(40, 1, 1);
        busy_mode = 0;
        flag_pct = 0;
        drain(150);
        chk("rand_frame_done", fd_cnt - fd0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
